// File: rtl/mul_sequencer.sv
// Control sequencer for a shift-add unsigned multiplier and its HI/LO pair.
// Issues load/step/write strobes, stalls the pipeline on hazards and selects the EX result source.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_maddu,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  input  logic             flush,
  output logic             mul_load,
  output logic             mul_step,
  output logic             hilo_we,
  output logic             hilo_acc,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [1:0]       sel,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             op_r;
  logic [CNT_W-1:0] cnt_r;

  // Next-state decode; start beats flush in IDLE, WRITE always commits.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = IDLE;
      end
      LOAD: begin
        if (flush) state_nxt_s = IDLE;
        else       state_nxt_s = RUN;
      end
      RUN: begin
        if (flush)                   state_nxt_s = IDLE;
        else if (cnt_r == LAST_STEP) state_nxt_s = WRITE;
        else                         state_nxt_s = RUN;
      end
      WRITE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operation latch and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && start) op_r <= op_maddu;
      else                          op_r <= op_r;
      case (state_r)
        LOAD:    cnt_r <= '0;
        RUN:     cnt_r <= cnt_r + CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Strobes are registered copies of the next-state decode so each one equals its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_load <= 1'b0;
      mul_step <= 1'b0;
      hilo_we  <= 1'b0;
      hilo_acc <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mul_load <= (state_nxt_s == LOAD);
      mul_step <= (state_nxt_s == RUN);
      hilo_we  <= (state_nxt_s == WRITE);
      hilo_acc <= (state_nxt_s == WRITE) & op_r;
      done     <= (state_nxt_s == WRITE);
      busy     <= (state_nxt_s != IDLE);
    end
  end

  assign step_cnt = cnt_r;
  assign stall    = busy & (start | mfhi_req | mflo_req);

  // Result select: a stalled EX forwards nothing; HI wins an illegal MFHI+MFLO.
  always_comb begin
    sel = 2'b00;
    if (stall)         sel = 2'b00;
    else if (mfhi_req) sel = 2'b01;
    else if (mflo_req) sel = 2'b10;
    else               sel = 2'b00;
  end

endmodule
